// File: rtl/id_stage_hz.sv
// Registered decode stage: field decode, register file with WB bypass, and a
// load-use interlock that inserts bubbles into the ID/EX register.
package id_stage_hz_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            valid_if_id;
  } if_id_reg_t;

  typedef struct packed {
    logic                      valid_id_ex;
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           rs1_data;
    logic [XLEN-1:0]           rs2_data;
    logic [XLEN-1:0]           immediate;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    ctrl_t                     ctrl;
  } id_ex_reg_t;
endpackage

module id_stage_hz
  import id_stage_hz_pkg::*;
#(
  parameter int XLEN               = id_stage_hz_pkg::XLEN,
  parameter int REG_ADDR_WIDTH     = id_stage_hz_pkg::REG_ADDR_WIDTH,
  parameter int WB_BYPASS          = 1,
  parameter int LOAD_USE_INTERLOCK = 1,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  if_id_reg_t                if_id_in,
  output logic                      id_ready,
  input  logic                      ex_ready,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]           wb_write_data,
  input  logic                      wb_reg_write,
  output id_ex_reg_t                id_ex_out,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  logic [31:0]               instr;
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  ctrl_t                     ctrl;
  logic [XLEN-1:0]           imm;
  logic [XLEN-1:0]           rs1_data, rs2_data;
  logic [XLEN-1:0]           regs [2**REG_ADDR_WIDTH];
  logic                      hz;
  id_ex_reg_t                decoded;

  assign instr  = if_id_in.instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  always_comb begin
    ctrl = '0;
    imm  = '0;
    unique case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = {instr[30], funct3};
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = {(funct3 == 3'b101) & instr[30], funct3};
        imm            = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        imm             = {{20{instr[31]}}, instr[31:20]};
      end
      OP_ST: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BR: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = 4'b1000;
        imm         = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        imm            = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JLR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LUI, OP_AUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**REG_ADDR_WIDTH; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_rd_addr != '0) begin
      regs[wb_rd_addr] <= wb_write_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (WB_BYPASS != 0 && wb_reg_write && wb_rd_addr != '0) begin
      if (wb_rd_addr == rs1) rs1_data = wb_write_data;
      if (wb_rd_addr == rs2) rs2_data = wb_write_data;
    end
    if (rs1 == '0) rs1_data = '0;
    if (rs2 == '0) rs2_data = '0;
  end

  assign hz = (LOAD_USE_INTERLOCK != 0) && if_id_in.valid_if_id &&
              id_ex_out.valid_id_ex && id_ex_out.ctrl.mem_read &&
              id_ex_out.rd_addr != '0 &&
              (id_ex_out.rd_addr == rs1 || id_ex_out.rd_addr == rs2);

  assign id_ready = reset && (flush || (ex_ready && !hz));

  always_comb begin
    decoded             = '0;
    decoded.valid_id_ex = if_id_in.valid_if_id;
    decoded.pc          = if_id_in.pc;
    decoded.rs1_data    = rs1_data;
    decoded.rs2_data    = rs2_data;
    decoded.immediate   = imm;
    decoded.rs1_addr    = rs1;
    decoded.rs2_addr    = rs2;
    decoded.rd_addr     = rd;
    decoded.funct3      = funct3;
    decoded.ctrl        = ctrl;
  end

  // Flush beats backpressure, backpressure beats the interlock bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_out   <= '0;
      stall_count <= '0;
    end else if (flush) begin
      id_ex_out <= '0;
    end else if (ex_ready) begin
      if (hz) begin
        id_ex_out <= '0;
        if (stall_count != '1) stall_count <= stall_count + 1'b1;
      end else begin
        id_ex_out <= decoded;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboarded bench for id_stage_hz: directed instruction vectors with
// hand-computed ID/EX payloads, plus direct checks of interlock and reset.
module tb_id_stage_hz;
  import id_stage_hz_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } exp_t;

  logic        clk;
  logic        reset;
  if_id_reg_t  if_id_in;
  logic        id_ready, nobp_ready;
  logic        ex_ready;
  logic        flush;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_write_data;
  logic        wb_reg_write;
  id_ex_reg_t  id_ex_out, nobp_out;
  logic [15:0] stall_count, nobp_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  id_stage_hz dut (
    .clk(clk), .reset(reset), .if_id_in(if_id_in), .id_ready(id_ready),
    .ex_ready(ex_ready), .flush(flush), .wb_rd_addr(wb_rd_addr),
    .wb_write_data(wb_write_data), .wb_reg_write(wb_reg_write),
    .id_ex_out(id_ex_out), .stall_count(stall_count)
  );

  id_stage_hz #(.WB_BYPASS(0)) u_nobp (
    .clk(clk), .reset(reset), .if_id_in(if_id_in), .id_ready(nobp_ready),
    .ex_ready(ex_ready), .flush(flush), .wb_rd_addr(wb_rd_addr),
    .wb_write_data(wb_write_data), .wb_reg_write(wb_reg_write),
    .id_ex_out(nobp_out), .stall_count(nobp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                               input logic rdy, input logic fl, input logic wb_en,
                               input logic [4:0] wb_addr, input logic [31:0] wb_data);
    if_id_in.instr       = instr;
    if_id_in.pc          = pc;
    if_id_in.valid_if_id = valid;
    ex_ready             = rdy;
    flush                = fl;
    wb_reg_write         = wb_en;
    wb_rd_addr           = wb_addr;
    wb_write_data        = wb_data;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every valid payload the register actually loaded is matched
  // against the oldest expectation.
  initial begin
    logic ld;
    exp_t e;
    forever begin
      @(posedge clk);
      ld = reset && ex_ready && !flush;
      #2;
      if (ld && id_ex_out.valid_id_ex) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_pc", id_ex_out.pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_pc", id_ex_out.pc, e.pc);
          checkOutput("sb_rd", 32'(id_ex_out.rd_addr), 32'(e.rd));
          checkOutput("sb_rs1_data", id_ex_out.rs1_data, e.rs1);
          checkOutput("sb_rs2_data", id_ex_out.rs2_data, e.rs2);
          checkOutput("sb_imm", id_ex_out.immediate, e.imm);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #3;
    checkOutput("rst_valid", 32'(id_ex_out.valid_id_ex), 32'd0);
    checkOutput("rst_ready", 32'(id_ready), 32'd0);
    checkOutput("rst_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADDI x1,x0,5 while WB writes x1=0x10
    applyStimulus(32'h00500093, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h10);
    push_exp(32'h0, 5'd1, 32'h0, 32'h0, 32'd5);
    #1 checkOutput("addi_ready", 32'(id_ready), 32'd1);
    step();
    checkOutput("addi_valid", 32'(id_ex_out.valid_id_ex), 32'd1);

    // LW x2,0(x1)
    applyStimulus(32'h0000A103, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    push_exp(32'h4, 5'd2, 32'h10, 32'h0, 32'h0);
    step();

    // ADD x3,x2,x1 right behind the load: one bubble
    applyStimulus(32'h001101B3, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 checkOutput("lu_ready_low", 32'(id_ready), 32'd0);
    step();
    checkOutput("lu_bubble", 32'(id_ex_out.valid_id_ex), 32'd0);
    checkOutput("lu_count", 32'(stall_count), 32'd1);
    push_exp(32'h8, 5'd3, 32'h0, 32'h10, 32'h0);
    #1 checkOutput("lu_ready_back", 32'(id_ready), 32'd1);
    step();
    checkOutput("lu_count_hold", 32'(stall_count), 32'd1);

    // LW x0,0(x1) then ADD x3,x0,x1: x0 destination never interlocks
    applyStimulus(32'h0000A003, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    push_exp(32'hC, 5'd0, 32'h10, 32'h0, 32'h0);
    step();
    applyStimulus(32'h001001B3, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    push_exp(32'h10, 5'd3, 32'h0, 32'h10, 32'h0);
    #1 checkOutput("x0_ready", 32'(id_ready), 32'd1);
    step();
    checkOutput("x0_count", 32'(stall_count), 32'd1);

    // ADD x6,x5,x5 with WB x5=0xDEADBEEF in the same cycle
    applyStimulus(32'h00528333, 32'h14, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    push_exp(32'h14, 5'd6, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    step();
    checkOutput("nobp_rs1_old", nobp_out.rs1_data, 32'h0);
    checkOutput("nobp_rs2_old", nobp_out.rs2_data, 32'h0);

    // Load-use stall killed by flush
    applyStimulus(32'h0000A103, 32'h18, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    push_exp(32'h18, 5'd2, 32'h10, 32'h0, 32'h0);
    step();
    applyStimulus(32'h001101B3, 32'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    #1 checkOutput("flush_ready", 32'(id_ready), 32'd1);
    step();
    checkOutput("flush_valid", 32'(id_ex_out.valid_id_ex), 32'd0);
    checkOutput("flush_count", 32'(stall_count), 32'd1);

    // SUB x7,x1,x1 then three cycles of EX backpressure
    applyStimulus(32'h401083B3, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    push_exp(32'h20, 5'd7, 32'h10, 32'h10, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h00500093, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      #1 checkOutput("hold_ready", 32'(id_ready), 32'd0);
      step();
      checkOutput("hold_valid", 32'(id_ex_out.valid_id_ex), 32'd1);
      checkOutput("hold_pc", id_ex_out.pc, 32'h20);
      checkOutput("hold_rd", 32'(id_ex_out.rd_addr), 32'd7);
      checkOutput("hold_rs1", id_ex_out.rs1_data, 32'h10);
      checkOutput("hold_alu_op", 32'(id_ex_out.ctrl.alu_op), 32'h8);
    end

    // Asynchronous reset in the middle of the hold
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(id_ex_out.valid_id_ex), 32'd0);
    checkOutput("mid_rst_pc", id_ex_out.pc, 32'h0);
    checkOutput("mid_rst_rs1", id_ex_out.rs1_data, 32'h0);
    checkOutput("mid_rst_count", 32'(stall_count), 32'd0);
    checkOutput("mid_rst_ready", 32'(id_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(32'h00500093, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    push_exp(32'h0, 5'd1, 32'h0, 32'h0, 32'd5);
    step();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
